btb_predictor: RTL and testbench

//  Parametrised branch target buffer with 2-bit saturating direction counters.

---
 rtl/btb_predictor.sv | 156 +++++++++++++++
 tb/tb_btb_predictor.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/btb_predictor.sv
// btb_predictor: direct-mapped branch target buffer with 2-bit saturating
// direction counters. Fetch lookup is combinational. Execute-stage updates
// are applied at the rising edge.
// Optional feature macro: BTB_PERF_EN (lookup / hit / mispredict counters).
module btb_predictor #(
   parameter int unsigned ENTRIES  = 16,
   parameter int unsigned ADDR_W   = 32,
   parameter logic [1:0]  CNT_INIT = 2'b01
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [ADDR_W-1:0] i_pcF,
   output logic              o_pred_taken,
   output logic [ADDR_W-1:0] o_pred_target,
   input  logic              i_upd_vld,
   input  logic [ADDR_W-1:0] i_upd_pc,
   input  logic              i_upd_is_jmp,
   input  logic              i_upd_taken,
   input  logic [ADDR_W-1:0] i_upd_target,
   input  logic              i_upd_mispred,
   input  logic              i_flush_all,
   output logic [31:0]       o_perf_lookups,
   output logic [31:0]       o_perf_hits,
   output logic [31:0]       o_perf_mispred
);

   localparam int unsigned IDX_W = $clog2(ENTRIES);
   localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

   logic              valid_q  [ENTRIES];
   logic              valid_d  [ENTRIES];
   logic [TAG_W-1:0]  tag_q    [ENTRIES];
   logic [TAG_W-1:0]  tag_d    [ENTRIES];
   logic [ADDR_W-1:0] target_q [ENTRIES];
   logic [ADDR_W-1:0] target_d [ENTRIES];
   logic              is_jmp_q [ENTRIES];
   logic              is_jmp_d [ENTRIES];
   logic [1:0]        cnt_q    [ENTRIES];
   logic [1:0]        cnt_d    [ENTRIES];

   logic [IDX_W-1:0]  fetch_idx;
   logic [TAG_W-1:0]  fetch_tag;
   logic              fetch_hit;
   logic [IDX_W-1:0]  upd_idx;
   logic [TAG_W-1:0]  upd_tag;
   logic              upd_hit;
   logic              unused_bits;

   // The two low PC bits are always zero for aligned instructions and are discarded.
   assign unused_bits = ^{i_pcF[1:0], i_upd_pc[1:0], i_upd_mispred};

   assign fetch_idx = i_pcF[IDX_W+1:2];
   assign fetch_tag = i_pcF[ADDR_W-1:IDX_W+2];
   assign upd_idx   = i_upd_pc[IDX_W+1:2];
   assign upd_tag   = i_upd_pc[ADDR_W-1:IDX_W+2];

   // Fetch lookup works on the registered table, so a same-cycle update is not yet visible.
   always_comb begin
      fetch_hit     = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
      o_pred_taken  = fetch_hit && (is_jmp_q[fetch_idx] || cnt_q[fetch_idx][1]);
      o_pred_target = o_pred_taken ? target_q[fetch_idx] : '0;
      upd_hit       = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
   end

   // Next table state: a flush has priority over an update and drops it.
   always_comb begin
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      is_jmp_d = is_jmp_q;
      cnt_d    = cnt_q;
      if (i_flush_all) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_d[i] = 1'b0;
            cnt_d[i]   = CNT_INIT;
         end
      end else if (i_upd_vld) begin
         if (upd_hit) begin
            is_jmp_d[upd_idx] = i_upd_is_jmp;
            if (i_upd_is_jmp) begin
               cnt_d[upd_idx]    = 2'b11;
               target_d[upd_idx] = i_upd_target;
            end else if (i_upd_taken) begin
               if (cnt_q[upd_idx] != 2'b11) begin
                  cnt_d[upd_idx] = cnt_q[upd_idx] + 2'b01;
               end
               target_d[upd_idx] = i_upd_target;
            end else begin
               if (cnt_q[upd_idx] != 2'b00) begin
                  cnt_d[upd_idx] = cnt_q[upd_idx] - 2'b01;
               end
            end
         end else if (i_upd_taken) begin
            valid_d[upd_idx]  = 1'b1;
            tag_d[upd_idx]    = upd_tag;
            target_d[upd_idx] = i_upd_target;
            is_jmp_d[upd_idx] = i_upd_is_jmp;
            cnt_d[upd_idx]    = i_upd_is_jmp ? 2'b11 : 2'b10;
         end
      end
   end

   // Table registers, cleared asynchronously.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            is_jmp_q[i] <= 1'b0;
            cnt_q[i]    <= CNT_INIT;
         end
      end else begin
         valid_q  <= valid_d;
         tag_q    <= tag_d;
         target_q <= target_d;
         is_jmp_q <= is_jmp_d;
         cnt_q    <= cnt_d;
      end
   end

`ifdef BTB_PERF_EN
   logic [31:0] perf_lookups_q, perf_lookups_d;
   logic [31:0] perf_hits_q, perf_hits_d;
   logic [31:0] perf_mispred_q, perf_mispred_d;

   // Free-running event counters; they wrap naturally and ignore flushes.
   always_comb begin
      perf_lookups_d = perf_lookups_q + 32'd1;
      perf_hits_d    = perf_hits_q + {31'd0, fetch_hit};
      perf_mispred_d = perf_mispred_q + {31'd0, i_upd_vld & i_upd_mispred};
   end

   // Counter registers, cleared only by reset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         perf_lookups_q <= '0;
         perf_hits_q    <= '0;
         perf_mispred_q <= '0;
      end else begin
         perf_lookups_q <= perf_lookups_d;
         perf_hits_q    <= perf_hits_d;
         perf_mispred_q <= perf_mispred_d;
      end
   end

   assign o_perf_lookups = perf_lookups_q;
   assign o_perf_hits    = perf_hits_q;
   assign o_perf_mispred = perf_mispred_q;
`else
   assign o_perf_lookups = '0;
   assign o_perf_hits    = '0;
   assign o_perf_mispred = '0;
`endif

endmodule

// File: tb/tb_btb_predictor.sv
// tb_btb_predictor: directed stimulus with a scoreboard queue; a monitor
// compares the lookup outputs at each falling edge against queued expectations.
module tb_btb_predictor;

   typedef struct {
      string       name;
      logic        taken;
      logic [31:0] target;
      logic        chk_perf;
      logic [31:0] look;
      logic [31:0] hit;
      logic [31:0] mis;
   } exp_t;

   logic        i_clk;
   logic        i_rst_n;
   logic [31:0] i_pcF;
   logic        o_pred_taken;
   logic [31:0] o_pred_target;
   logic        i_upd_vld;
   logic [31:0] i_upd_pc;
   logic        i_upd_is_jmp;
   logic        i_upd_taken;
   logic [31:0] i_upd_target;
   logic        i_upd_mispred;
   logic        i_flush_all;
   logic [31:0] o_perf_lookups;
   logic [31:0] o_perf_hits;
   logic [31:0] o_perf_mispred;

   exp_t        sb_q[$];
   logic        chk_vld;
   int          assertions;
   int          failures;
   logic        pend_chk_perf;
   logic [31:0] pend_look;
   logic [31:0] pend_hit;
   logic [31:0] pend_mis;

   btb_predictor #(.ENTRIES(16), .ADDR_W(32), .CNT_INIT(2'b01)) dut (
      .i_clk          (i_clk),
      .i_rst_n        (i_rst_n),
      .i_pcF          (i_pcF),
      .o_pred_taken   (o_pred_taken),
      .o_pred_target  (o_pred_target),
      .i_upd_vld      (i_upd_vld),
      .i_upd_pc       (i_upd_pc),
      .i_upd_is_jmp   (i_upd_is_jmp),
      .i_upd_taken    (i_upd_taken),
      .i_upd_target   (i_upd_target),
      .i_upd_mispred  (i_upd_mispred),
      .i_flush_all    (i_flush_all),
      .o_perf_lookups (o_perf_lookups),
      .o_perf_hits    (o_perf_hits),
      .o_perf_mispred (o_perf_mispred)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
      assertions++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // One cycle of stimulus: drive just after the rising edge and queue the expected lookup result.
   task automatic applyStimulus(input string nm, input logic [31:0] pc,
                                input logic uv, input logic [31:0] upc, input logic jmp,
                                input logic tk, input logic [31:0] tgt, input logic mis,
                                input logic fl, input logic rp,
                                input logic etk, input logic [31:0] etgt);
      exp_t it;
      @(posedge i_clk);
      #1;
      i_pcF         = pc;
      i_upd_vld     = uv;
      i_upd_pc      = upc;
      i_upd_is_jmp  = jmp;
      i_upd_taken   = tk;
      i_upd_target  = tgt;
      i_upd_mispred = mis;
      i_flush_all   = fl;
      it.name       = nm;
      it.taken      = etk;
      it.target     = etgt;
      it.chk_perf   = pend_chk_perf;
      it.look       = pend_look;
      it.hit        = pend_hit;
      it.mis        = pend_mis;
      pend_chk_perf = 1'b0;
      sb_q.push_back(it);
      chk_vld = 1'b1;
      if (rp) begin
         #1 i_rst_n = 1'b0;
         #1 i_rst_n = 1'b1;
      end
   endtask

   task automatic lookup(input string nm, input logic [31:0] pc, input logic etk, input logic [31:0] etgt);
      applyStimulus(nm, pc, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, etk, etgt);
   endtask

   task automatic update(input string nm, input logic [31:0] pc, input logic [31:0] upc, input logic jmp,
                         input logic tk, input logic [31:0] tgt, input logic etk, input logic [31:0] etgt);
      applyStimulus(nm, pc, 1'b1, upc, jmp, tk, tgt, 1'b0, 1'b0, 1'b0, etk, etgt);
   endtask

   // Monitor: pop one expectation per checked cycle, mid-cycle away from the rising edge.
   always @(negedge i_clk) begin
      exp_t item;
      if (chk_vld) begin
         if (sb_q.size() == 0) begin
            assertions++;
            failures++;
            $display("[TB] FAIL sb_underflow: got empty queue expected an entry");
         end else begin
            item = sb_q.pop_front();
            checkOutput({item.name, ".taken"}, {31'd0, o_pred_taken}, {31'd0, item.taken});
            checkOutput({item.name, ".target"}, o_pred_target, item.target);
            if (item.chk_perf) begin
               checkOutput({item.name, ".lookups"}, o_perf_lookups, item.look);
               checkOutput({item.name, ".hits"}, o_perf_hits, item.hit);
               checkOutput({item.name, ".mispred"}, o_perf_mispred, item.mis);
            end
         end
      end
   end

   // Directed sequence; index = pc[5:2], tag = pc[31:6] for 16 entries.
   initial begin
      assertions    = 0;
      failures      = 0;
      chk_vld       = 1'b0;
      pend_chk_perf = 1'b0;
      pend_look     = 32'd0;
      pend_hit      = 32'd0;
      pend_mis      = 32'd0;
      i_rst_n       = 1'b0;
      i_pcF         = 32'h100;
      i_upd_vld     = 1'b0;
      i_upd_pc      = 32'h0;
      i_upd_is_jmp  = 1'b0;
      i_upd_taken   = 1'b0;
      i_upd_target  = 32'h0;
      i_upd_mispred = 1'b0;
      i_flush_all   = 1'b0;

      lookup("in_reset", 32'h100, 1'b0, 32'h0);
      #5 i_rst_n = 1'b1;

      lookup("after_reset", 32'h100, 1'b0, 32'h0);
      update("alloc_same_cycle", 32'h100, 32'h100, 1'b0, 1'b1, 32'h200, 1'b0, 32'h0);
      lookup("br_alloc_cnt10", 32'h100, 1'b1, 32'h200);
      update("nt1_sees10", 32'h100, 32'h100, 1'b0, 1'b0, 32'h999, 1'b1, 32'h200);
      update("nt2_sees01", 32'h100, 32'h100, 1'b0, 1'b0, 32'h999, 1'b0, 32'h0);
      update("nt3_sees00", 32'h100, 32'h100, 1'b0, 1'b0, 32'h999, 1'b0, 32'h0);
      update("tk1_sees00", 32'h100, 32'h100, 1'b0, 1'b1, 32'h200, 1'b0, 32'h0);
      update("tk2_sees01", 32'h100, 32'h100, 1'b0, 1'b1, 32'h200, 1'b0, 32'h0);
      update("tk3_sees10", 32'h100, 32'h100, 1'b0, 1'b1, 32'h200, 1'b1, 32'h200);
      update("tk4_sees11", 32'h100, 32'h100, 1'b0, 1'b1, 32'h200, 1'b1, 32'h200);
      update("nt_sees11_sat", 32'h100, 32'h100, 1'b0, 1'b0, 32'h999, 1'b1, 32'h200);
      update("nt_sees10", 32'h100, 32'h100, 1'b0, 1'b0, 32'h999, 1'b1, 32'h200);
      lookup("cnt01_not_taken", 32'h100, 1'b0, 32'h0);
      update("retarget_sees01", 32'h100, 32'h100, 1'b0, 1'b1, 32'h240, 1'b0, 32'h0);
      lookup("retarget", 32'h100, 1'b1, 32'h240);
      update("jmp_hit_upd", 32'h100, 32'h100, 1'b1, 1'b1, 32'h180, 1'b1, 32'h240);
      update("alias_alloc", 32'h100, 32'h140, 1'b0, 1'b1, 32'h400, 1'b1, 32'h180);
      lookup("alias_old_miss", 32'h100, 1'b0, 32'h0);
      lookup("alias_new_hit", 32'h140, 1'b1, 32'h400);
      lookup("low_bits_ignored", 32'h143, 1'b1, 32'h400);
      update("miss_nt_upd", 32'h140, 32'h180, 1'b0, 1'b0, 32'h800, 1'b1, 32'h400);
      lookup("miss_nt_nochange", 32'h140, 1'b1, 32'h400);
      update("jmp_alloc_upd", 32'h204, 32'h204, 1'b1, 1'b1, 32'h500, 1'b0, 32'h0);
      lookup("jmp_alloc_hit", 32'h204, 1'b1, 32'h500);
      applyStimulus("flush_cycle", 32'h140, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h400);
      lookup("flush_jmp_gone", 32'h204, 1'b0, 32'h0);
      update("same_cycle_0x300", 32'h300, 32'h300, 1'b0, 1'b1, 32'h600, 1'b0, 32'h0);
      lookup("next_cycle_0x300", 32'h300, 1'b1, 32'h600);
      applyStimulus("flush_with_upd", 32'h300, 1'b1, 32'h340, 1'b1, 1'b1, 32'h700, 1'b0, 1'b1, 1'b0, 1'b1, 32'h600);
      lookup("flush_upd_dropped", 32'h340, 1'b0, 32'h0);
      lookup("flush_all_miss", 32'h300, 1'b0, 32'h0);
      update("realloc_0x300", 32'h300, 32'h300, 1'b0, 1'b1, 32'h600, 1'b0, 32'h0);
      lookup("realloc_hit", 32'h300, 1'b1, 32'h600);
      applyStimulus("async_reset", 32'h300, 1'b1, 32'h340, 1'b1, 1'b1, 32'h700, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      lookup("post_reset_upd", 32'h340, 1'b1, 32'h700);
      lookup("post_reset_old", 32'h300, 1'b0, 32'h0);

      applyStimulus("perf0", 32'h100, 1'b1, 32'h100, 1'b1, 1'b1, 32'h180, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      applyStimulus("perf1", 32'h100, 1'b1, 32'h204, 1'b0, 1'b1, 32'h500, 1'b1, 1'b0, 1'b0, 1'b1, 32'h180);
      lookup("perf2", 32'h204, 1'b1, 32'h500);
      lookup("perf3", 32'h208, 1'b0, 32'h0);
      lookup("perf4", 32'h100, 1'b1, 32'h180);
      lookup("perf5", 32'h140, 1'b0, 32'h0);
      lookup("perf6", 32'h204, 1'b1, 32'h500);
      applyStimulus("perf7", 32'h300, 1'b0, 32'h100, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      lookup("perf8", 32'h300, 1'b0, 32'h0);
      lookup("perf9", 32'h300, 1'b0, 32'h0);
`ifdef BTB_PERF_EN
      pend_look = 32'd10;
      pend_hit  = 32'd4;
      pend_mis  = 32'd2;
`else
      pend_look = 32'd0;
      pend_hit  = 32'd0;
      pend_mis  = 32'd0;
`endif
      pend_chk_perf = 1'b1;
      lookup("perf_counters", 32'h100, 1'b1, 32'h180);

      @(negedge i_clk);
      #1;
      chk_vld = 1'b0;
      checkOutput("sb_drained", sb_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
